mram_addr_stp: RTL
==================

Name: mram_addr_stp

Overview:
- Serial-to-parallel address capture stage, directly downstream of the burst control block.
- Selects between the host serial address line and the burst controller's serial address output using addr_sel.
- Deserialises one ADDR_W-bit address frame, MSB first, and presents it to the MRAM interface with a valid/ready handshake.
- Flags overrun when serial bits arrive while a captured address is still unconsumed.

Parameters:
- ADDR_W, 8: address width in bits; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- addr_sel  in  1  source select; 0 = host_addr_ser, 1 = burst_addr_ser; sampled on frame start
- host_addr_ser  in  1  serial address from host
- burst_addr_ser  in  1  serial address from burst controller (its addr_ser_out)
- bit_valid  in  1  qualifies the serial bit this cycle
- frame_start  in  1  with bit_valid, marks the first (MSB) bit of a frame
- addr_ready  in  1  downstream accepts addr_par
- clr_err  in  1  clears sticky overrun
- addr_par  out  ADDR_W  captured address
- addr_valid  out  1  addr_par valid
- busy  out  1  state != IDLE
- overrun  out  1  sticky overrun flag
- parity_err  out  1  parity mismatch; tied 0 when feature is compiled out

Behaviour:
- Reset: every output is 0; state = IDLE; shift register, counter and latched select are cleared. A reset mid-frame discards the partial frame, and the outputs read 0 in the cycle after rst is sampled.
- Serial bit = addr_sel_q ? burst_addr_ser : host_addr_ser.
- addr_sel_q is loaded from addr_sel on the accepted frame-start bit and held for the whole frame. Changes to addr_sel mid-frame are ignored.
- States: IDLE, SHIFT, HOLD (plus PAR when STP_PARITY_EN is defined).
- IDLE:
  - bit_valid & frame_start: shreg <= {.., bit}, cnt <= 1, latch select, go to SHIFT.
  - bit_valid without frame_start is ignored; no error.
- SHIFT:
  - Each bit_valid: shreg <= {shreg[ADDR_W-2:0], bit}, cnt++.
  - bit_valid low: hold state; gaps of any length are allowed.
  - On the bit where cnt == ADDR_W-1: addr_par <= final value, addr_valid <= 1, go to HOLD. addr_valid rises one cycle after the last bit is sampled.
  - bit_valid & frame_start in SHIFT: abort the partial frame and restart with this bit as the MSB (cnt <= 1, re-latch select). No error is flagged.
- HOLD:
  - addr_par and addr_valid are held stable until addr_valid & addr_ready.
  - On handshake: addr_valid <= 0 next cycle, go to IDLE.
  - bit_valid in HOLD with no handshake that cycle: bit dropped, overrun <= 1.
  - Handshake plus bit_valid & frame_start in the same cycle: accept the new frame's MSB, go to SHIFT, no overrun.
  - Handshake plus bit_valid without frame_start: bit dropped, overrun <= 1.
- overrun stays set until clr_err or rst. If clr_err and a new overrun event occur in the same cycle, set wins.
- cnt width: $clog2(ADDR_W+1). It wraps only via return to IDLE; no other wrap path exists.

Optional Feature:
- Macro: STP_PARITY_EN.
- Defined:
  - After ADDR_W address bits, go to PAR and wait for one more valid bit: an even-parity bit over the address.
  - On that bit: addr_valid <= 1, parity_err <= (^addr ^ pbit); go to HOLD.
  - parity_err is held with addr_valid and cleared on handshake.
  - frame_start in PAR restarts the frame, as in SHIFT.
- Undefined: there is no PAR state; parity_err is constant 0.

Decomposition:
- Package stp_pkg holds:
  - the state enum typedef (IDLE/SHIFT/HOLD/PAR);
  - the default ADDR_W constant;
  - the counter-width function.
- One sub-module is natural: stp_shift_reg (ADDR_W-bit shift register with load-on-start and shift-enable). The FSM, handshake and error logic stay in the top.

Test Plan:
1. ADDR_W=8, addr_sel=0, 0xA5 on host line, bit_valid continuous, addr_ready=1 -> addr_valid high exactly one cycle, starting the cycle after the 8th bit, addr_par=0xA5; busy=0 the following cycle.
2. addr_sel=1 at frame start, toggled to 0 after bit 3, 0x3C on burst line -> addr_par=0x3C; the host line is never sampled.
3. 0x5A sent with bit_valid every other cycle -> addr_par=0x5A; valid one cycle after the 8th valid bit; busy high throughout.
4. 0x0F captured, addr_ready=0 for 4 cycles, one bit_valid pulse during HOLD -> addr_par remains 0x0F; overrun=1 stays set after the handshake until clr_err pulses, then 0.
5. Frame started, frame_start reasserted at bit 4, then 0x81 sent -> single addr_valid with addr_par=0x81; overrun=0.
6. rst asserted at bit 5 of a frame -> all outputs 0 next cycle; a following frame of 0xFF is captured correctly. With STP_PARITY_EN: 0xFF plus pbit=1 -> parity_err=1; with pbit=0 -> parity_err=0.

Source files
------------

// File: rtl/stp_pkg.sv
// +-----------------------------------------------------------------------------
// | Module : stp_pkg
// | Desc   : Shared types and helpers for the mram_addr_stp address deserialiser.
// | Rev    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package stp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        PAR   = 2'd3
    } stp_state_t;

    localparam int c_ADDR_W_DEFAULT = 8;

    // Counter must be able to hold ADDR_W itself after the last address bit.
    function automatic int stp_cnt_width(input int addr_w);
        return $clog2(addr_w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stp_shift_reg.sv
// +-----------------------------------------------------------------------------
// | Module : stp_shift_reg
// | Desc   : MSB-first shift register; load restarts it with one bit, shift appends.
// | Rev    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module stp_shift_reg #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic [ADDR_W-1:0] o_q
);

    logic [ADDR_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= {{(ADDR_W-1){1'b0}}, i_bit};
        end else if (i_shift) begin
            r_q <= {r_q[ADDR_W-2:0], i_bit};
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/mram_addr_stp.sv
// +-----------------------------------------------------------------------------
// | Module : mram_addr_stp
// | Desc   : Serial-to-parallel address capture with valid/ready output and
// |          sticky overrun. Optional trailing even-parity bit: STP_PARITY_EN.
// | Rev    : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module mram_addr_stp
    import stp_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_sel,
    input  logic              host_addr_ser,
    input  logic              burst_addr_ser,
    input  logic              bit_valid,
    input  logic              frame_start,
    input  logic              addr_ready,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] addr_par,
    output logic              addr_valid,
    output logic              busy,
    output logic              overrun,
    output logic              parity_err
);

    localparam int c_CNT_W = stp_cnt_width(ADDR_W);

    stp_state_t        r_state;
    stp_state_t        w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_sel;
    logic [ADDR_W-1:0] r_addr_par;
    logic              r_addr_valid;
    logic              r_overrun;
    logic [ADDR_W-1:0] w_shreg;

    logic w_start;
    logic w_hs;
    logic w_bit;
    logic w_load;
    logic w_shift;
    logic w_capture;
    logic w_valid_set;
    logic w_to_idle;
    logic w_ovr_set;

    assign w_start = bit_valid & frame_start;
    assign w_hs    = r_addr_valid & addr_ready;
    // The frame's MSB must already come from the newly selected source.
    assign w_bit   = (w_start ? addr_sel : r_sel) ? burst_addr_ser : host_addr_ser;

    stp_shift_reg #(
        .ADDR_W (ADDR_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_bit   (w_bit),
        .o_q     (w_shreg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

`ifdef STP_PARITY_EN
    logic w_par_done;
    logic r_parity_err;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_capture   = 1'b0;
        w_to_idle   = 1'b0;
        w_ovr_set   = 1'b0;
`ifdef STP_PARITY_EN
        w_par_done  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_start) begin
                    w_load = 1'b1;
                end else if (bit_valid) begin
                    w_shift = 1'b1;
                    if (r_cnt == c_CNT_W'(ADDR_W - 1)) begin
                        w_capture   = 1'b1;
`ifdef STP_PARITY_EN
                        w_state_nxt = PAR;
`else
                        w_state_nxt = HOLD;
`endif
                    end
                end
            end
`ifdef STP_PARITY_EN
            PAR: begin
                if (w_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else if (bit_valid) begin
                    w_par_done  = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
`endif
            HOLD: begin
                if (w_hs && w_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    if (w_hs) begin
                        w_to_idle   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                    w_ovr_set = bit_valid;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef STP_PARITY_EN
    assign w_valid_set = w_par_done;
`else
    assign w_valid_set = w_capture;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_sel        <= 1'b0;
            r_addr_par   <= '0;
            r_addr_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt <= c_CNT_W'(1);
                r_sel <= addr_sel;
            end else if (w_shift) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else if (w_to_idle) begin
                r_cnt <= '0;
            end

            if (w_capture) begin
                r_addr_par <= {w_shreg[ADDR_W-2:0], w_bit};
            end

            if (w_valid_set) begin
                r_addr_valid <= 1'b1;
            end else if (w_hs) begin
                r_addr_valid <= 1'b0;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef STP_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_par_done) begin
            r_parity_err <= (^r_addr_par) ^ w_bit;
        end else if (w_hs) begin
            r_parity_err <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign addr_par   = r_addr_par;
    assign addr_valid = r_addr_valid;
    assign busy       = (r_state != IDLE);
    assign overrun    = r_overrun;

endmodule

`default_nettype wire
